// File: rtl/fp16_pkg.sv
// ============================================================================
// Module   : fp16_pkg
// Purpose  : Shared fp16 field geometry, scheduler FSM state type and field
//            extraction helpers for the fp16 alignment scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp16_pkg;

    localparam int FP16_EXP_W    = 5;
    localparam int FP16_MANT_W   = 10;
    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RESP  = 2'd2
    } fsm_state_t;

    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [15:0] op);
        return op[FP16_EXP_MSB:FP16_EXP_LSB];
    endfunction

    function automatic logic [FP16_MANT_W-1:0] fp16_mant(input logic [15:0] op);
        return op[FP16_MANT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp16_rr_arb2.sv
// ============================================================================
// Module   : fp16_rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone request is granted directly;
//            on a tie the requester that was NOT granted last wins.
// Ports    : req[1:0]  - request vector
//            last_gnt  - index of the requester granted most recently
//            gnt[1:0]  - one-hot grant (all zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fp16_align_sched.sv
// ============================================================================
// Module   : fp16_align_sched
// Purpose  : Schedules operand pairs from two requesters onto one external
//            combinational fp16 alignment unit and returns the aligned result
//            with a ready/valid response handshake.
//            IDLE -> (accept) -> ALIGN -> RESP -> (rsp handshake) -> IDLE
// Ports    : clk, rst_n (async, active low)
//            req{0,1}_valid/ready, req{0,1}_opa/opb  - requester side
//            aln_exp_a/b, aln_mant_a/b               - registered unit drive
//            aln_mant_a_out/b_out, aln_exp_out,
//            aln_sticky, aln_exc                     - unit results
//            rsp_valid/ready, rsp_id, rsp_*          - response side
//            exc_count[7:0]                          - optional, see below
// Config   : FP16_ALIGN_SCHED_EXC_CNT_EN adds exc_count, a saturating count of
//            response handshakes carrying rsp_exc=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_align_sched
    import fp16_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [15:0]            req0_opa,
    input  logic [15:0]            req0_opb,
    input  logic [15:0]            req1_opa,
    input  logic [15:0]            req1_opb,

    output logic [FP16_EXP_W-1:0]  aln_exp_a,
    output logic [FP16_EXP_W-1:0]  aln_exp_b,
    output logic [FP16_MANT_W-1:0] aln_mant_a,
    output logic [FP16_MANT_W-1:0] aln_mant_b,
    input  logic [FP16_MANT_W-1:0] aln_mant_a_out,
    input  logic [FP16_MANT_W-1:0] aln_mant_b_out,
    input  logic [FP16_EXP_W-1:0]  aln_exp_out,
    input  logic                   aln_sticky,
    input  logic                   aln_exc,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [FP16_MANT_W-1:0] rsp_mant_a,
    output logic [FP16_MANT_W-1:0] rsp_mant_b,
    output logic [FP16_EXP_W-1:0]  rsp_exp,
    output logic                   rsp_sticky,
    output logic                   rsp_exc,
    output logic                   rsp_sign_a,
    output logic                   rsp_sign_b
`ifdef FP16_ALIGN_SCHED_EXC_CNT_EN
    ,
    output logic [7:0]             exc_count
`endif
);

    fsm_state_t             r_state;
    fsm_state_t             w_next_state;

    logic                   r_last_gnt;
    logic [1:0]             w_gnt;
    logic                   w_accept;
    logic                   w_sel_id;
    logic [15:0]            w_sel_opa;
    logic [15:0]            w_sel_opb;
    logic                   w_rsp_fire;

    logic [FP16_EXP_W-1:0]  r_aln_exp_a;
    logic [FP16_EXP_W-1:0]  r_aln_exp_b;
    logic [FP16_MANT_W-1:0] r_aln_mant_a;
    logic [FP16_MANT_W-1:0] r_aln_mant_b;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic                   r_id;
    logic [FP16_MANT_W-1:0] r_rsp_mant_a;
    logic [FP16_MANT_W-1:0] r_rsp_mant_b;
    logic [FP16_EXP_W-1:0]  r_rsp_exp;
    logic                   r_rsp_sticky;
    logic                   r_rsp_exc;

    // Requests only compete while IDLE, so a grant outside IDLE can never
    // turn into a ready or an accept.
    fp16_rr_arb2 u_arb (
        .req      ({req1_valid, req0_valid}),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt)
    );

    assign w_accept   = (r_state == IDLE) && (w_gnt != 2'b00);
    assign w_sel_id   = w_gnt[1];
    assign w_sel_opa  = w_sel_id ? req1_opa : req0_opa;
    assign w_sel_opb  = w_sel_id ? req1_opb : req0_opb;
    assign w_rsp_fire = (r_state == RESP) && rsp_ready;

    assign req0_ready = (r_state == IDLE) && w_gnt[0];
    assign req1_ready = (r_state == IDLE) && w_gnt[1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = ALIGN;
            ALIGN:                   w_next_state = RESP;
            RESP:    if (rsp_ready)  w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture on accept, result capture in ALIGN.
    // Result registers are only written in ALIGN, so they stay frozen for
    // as long as RESP is back-pressured.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_aln_exp_a  <= '0;
            r_aln_exp_b  <= '0;
            r_aln_mant_a <= '0;
            r_aln_mant_b <= '0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_mant_a <= '0;
            r_rsp_mant_b <= '0;
            r_rsp_exp    <= '0;
            r_rsp_sticky <= 1'b0;
            r_rsp_exc    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_aln_exp_a  <= fp16_exp(w_sel_opa);
                r_aln_exp_b  <= fp16_exp(w_sel_opb);
                r_aln_mant_a <= fp16_mant(w_sel_opa);
                r_aln_mant_b <= fp16_mant(w_sel_opb);
                r_sign_a     <= w_sel_opa[FP16_SIGN_BIT];
                r_sign_b     <= w_sel_opb[FP16_SIGN_BIT];
                r_id         <= w_sel_id;
                r_last_gnt   <= w_sel_id;
            end
            if (r_state == ALIGN) begin
                r_rsp_mant_a <= aln_mant_a_out;
                r_rsp_mant_b <= aln_mant_b_out;
                r_rsp_exp    <= aln_exp_out;
                r_rsp_sticky <= aln_sticky;
                r_rsp_exc    <= aln_exc;
            end
        end
    end

    assign aln_exp_a  = r_aln_exp_a;
    assign aln_exp_b  = r_aln_exp_b;
    assign aln_mant_a = r_aln_mant_a;
    assign aln_mant_b = r_aln_mant_b;

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_mant_a = r_rsp_mant_a;
    assign rsp_mant_b = r_rsp_mant_b;
    assign rsp_exp    = r_rsp_exp;
    assign rsp_sticky = r_rsp_sticky;
    assign rsp_exc    = r_rsp_exc;
    assign rsp_sign_a = r_sign_a;
    assign rsp_sign_b = r_sign_b;

`ifdef FP16_ALIGN_SCHED_EXC_CNT_EN
    logic [7:0] r_exc_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_count <= 8'd0;
        end else if (w_rsp_fire && r_rsp_exc && (r_exc_count != 8'hFF)) begin
            r_exc_count <= r_exc_count + 8'd1;
        end
    end

    assign exc_count = r_exc_count;
`else
    // Handshake strobe only feeds the optional counter.
    logic w_unused;
    assign w_unused = w_rsp_fire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp16_align_sched.sv
// ============================================================================
// Module   : tb_fp16_align_sched
// Purpose  : Self-checking bench for fp16_align_sched. Provides a behavioural
//            alignment unit, a transaction-level scheduler model and directed
//            vectors. FP16_ALIGN_SCHED_EXC_CNT_EN enables the counter test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp16_align_sched;

    typedef struct packed {
        logic       id;
        logic       sa;
        logic       sb;
        logic       ex;
        logic       st;
        logic [4:0] e;
        logic [9:0] ma;
        logic [9:0] mb;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic [4:0]  aln_exp_a, aln_exp_b, aln_exp_out;
    logic [9:0]  aln_mant_a, aln_mant_b, aln_mant_a_out, aln_mant_b_out;
    logic        aln_sticky, aln_exc;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [9:0]  rsp_mant_a, rsp_mant_b;
    logic [4:0]  rsp_exp;
    logic        rsp_sticky, rsp_exc, rsp_sign_a, rsp_sign_b;
`ifdef FP16_ALIGN_SCHED_EXC_CNT_EN
    logic [7:0]  exc_count;
`endif

    int total = 0;
    int bad   = 0;

    fp16_align_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req1_valid     (req1_valid),
        .req0_ready     (req0_ready),
        .req1_ready     (req1_ready),
        .req0_opa       (req0_opa),
        .req0_opb       (req0_opb),
        .req1_opa       (req1_opa),
        .req1_opb       (req1_opb),
        .aln_exp_a      (aln_exp_a),
        .aln_exp_b      (aln_exp_b),
        .aln_mant_a     (aln_mant_a),
        .aln_mant_b     (aln_mant_b),
        .aln_mant_a_out (aln_mant_a_out),
        .aln_mant_b_out (aln_mant_b_out),
        .aln_exp_out    (aln_exp_out),
        .aln_sticky     (aln_sticky),
        .aln_exc        (aln_exc),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_mant_a     (rsp_mant_a),
        .rsp_mant_b     (rsp_mant_b),
        .rsp_exp        (rsp_exp),
        .rsp_sticky     (rsp_sticky),
        .rsp_exc        (rsp_exc),
        .rsp_sign_a     (rsp_sign_a),
        .rsp_sign_b     (rsp_sign_b)
`ifdef FP16_ALIGN_SCHED_EXC_CNT_EN
        ,
        .exc_count      (exc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural alignment unit: larger exponent wins, the other mantissa is
    // shifted right, bits shifted out set sticky, exp==31 flags an exception.
    function automatic rsp_t align(input logic [4:0] ea, input logic [4:0] eb,
                                   input logic [9:0] ma, input logic [9:0] mb);
        rsp_t       r;
        int         d;
        logic [9:0] mask;
        r    = '0;
        r.ex = (ea == 5'd31) || (eb == 5'd31);
        d    = (ea >= eb) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        mask = (d >= 10) ? 10'h3FF : 10'((1 << d) - 1);
        if (ea >= eb) begin
            r.e  = ea;
            r.ma = ma;
            r.mb = (d >= 10) ? 10'd0 : (mb >> d);
            r.st = |(mb & mask);
        end else begin
            r.e  = eb;
            r.mb = mb;
            r.ma = (d >= 10) ? 10'd0 : (ma >> d);
            r.st = |(ma & mask);
        end
        return r;
    endfunction

    rsp_t unit_res;
    always_comb begin
        unit_res       = align(aln_exp_a, aln_exp_b, aln_mant_a, aln_mant_b);
        aln_mant_a_out = unit_res.ma;
        aln_mant_b_out = unit_res.mb;
        aln_exp_out    = unit_res.e;
        aln_sticky     = unit_res.st;
        aln_exc        = unit_res.ex;
    end

    // ------------------------------------------------------------------
    // Transaction-level model: m_phase counts cycles since accept
    // (0 idle, 1 operands at the unit, 2 response offered).
    // ------------------------------------------------------------------
    int         m_phase = 0;
    int         m_last  = 1;
    rsp_t       m_rsp;
    logic [4:0] m_ea, m_eb;
    logic [9:0] m_ma, m_mb;

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 1) ? 0 : 1;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    always @(negedge rst_n) begin
        m_phase = 0;
        m_last  = 1;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_phase == 0) begin
                int          g;
                logic [15:0] a, b;
                g = pick(req0_valid, req1_valid, m_last);
                if (g >= 0) begin
                    a       = (g == 1) ? req1_opa : req0_opa;
                    b       = (g == 1) ? req1_opb : req0_opb;
                    m_ea    = a[14:10];
                    m_eb    = b[14:10];
                    m_ma    = a[9:0];
                    m_mb    = b[9:0];
                    m_rsp   = align(a[14:10], b[14:10], a[9:0], b[9:0]);
                    m_rsp.id = (g == 1);
                    m_rsp.sa = a[15];
                    m_rsp.sb = b[15];
                    m_last  = g;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (rsp_ready) begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_aln_exp_a", aln_exp_a, 0);
            chk("rst_rsp_mant_a", rsp_mant_a, 0);
        end else begin
            int g;
            g = pick(req0_valid, req1_valid, m_last);
            chk("ready0", req0_ready, (m_phase == 0) && (g == 0));
            chk("ready1", req1_ready, (m_phase == 0) && (g == 1));
            chk("rsp_valid", rsp_valid, m_phase == 2);
            if (m_phase == 1) begin
                chk("aln_drive", {aln_exp_a, aln_exp_b, aln_mant_a, aln_mant_b},
                    {m_ea, m_eb, m_ma, m_mb});
            end
            if (m_phase == 2) begin
                chk("rsp_fields", {rsp_id, rsp_sign_a, rsp_sign_b, rsp_exc, rsp_sticky,
                                   rsp_exp, rsp_mant_a, rsp_mant_b}, m_rsp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every helper starts and ends 1 time unit after a
    // rising edge.
    // ------------------------------------------------------------------
    task automatic send(input int r, input logic [15:0] a, input logic [15:0] b);
        int n;
        if (r == 1) begin req1_opa = a; req1_opb = b; req1_valid = 1'b1; end
        else        begin req0_opa = a; req0_opb = b; req0_valid = 1'b1; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((r == 1) ? req1_ready : req0_ready) && n < 20);
        if (n >= 20) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        if (r == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic get_rsp(output rsp_t res);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (n >= 20) chk("rsp_timeout", 1, 0);
        res = {rsp_id, rsp_sign_a, rsp_sign_b, rsp_exc, rsp_sticky, rsp_exp, rsp_mant_a, rsp_mant_b};
        @(posedge clk); #1;
    endtask

    typedef struct { int r; logic [15:0] a; logic [15:0] b; } vec_t;
    vec_t vecs[6] = '{
        '{0, 16'h3C01, 16'h4400},
        '{1, 16'h4400, 16'h3C03},
        '{0, 16'h0001, 16'h7800},
        '{1, 16'h5555, 16'h2AAA},
        '{0, 16'h7C00, 16'h7E00},
        '{1, 16'h3FFF, 16'h3FFF}
    };

    initial begin
        rsp_t r;
        int   seen;
        int   ids[4];
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opa = '0; req0_opb = '0; req1_opa = '0; req1_opb = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while the pair sits at the alignment unit: it must vanish.
        send(0, 16'h4800, 16'h3C00);
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
        chk("no_rsp_after_rst", seen, 0);
        @(posedge clk); #1;

        // Tie held for four transactions: 0,1,0,1.
        req0_opa = 16'h4800; req0_opb = 16'h3C00; req0_valid = 1'b1;
        req1_opa = 16'hC000; req1_opb = 16'h4000; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin get_rsp(r); ids[i] = int'(r.id); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_id0", ids[0], 0);
        chk("tie_id1", ids[1], 1);
        chk("tie_id2", ids[2], 0);
        chk("tie_id3", ids[3], 1);

        // Single request with literal exponents.
        send(0, 16'h4800, 16'h3C00);
        @(negedge clk);
        chk("lit_aln_exp_a", aln_exp_a, 18);
        chk("lit_aln_exp_b", aln_exp_b, 15);
        get_rsp(r);
        chk("lit_single_id", r.id, 0);
        chk("lit_single_exp", r.e, 18);

        // Signs.
        send(1, 16'hC000, 16'h4000);
        get_rsp(r);
        chk("lit_sign_a", r.sa, 1);
        chk("lit_sign_b", r.sb, 0);
        chk("lit_sign_id", r.id, 1);

        // Exception pass-through.
        send(0, 16'h7C00, 16'h3C00);
        get_rsp(r);
        chk("lit_exc", r.ex, 1);

        // Backpressure: response frozen, no ready while held.
        rsp_ready = 1'b0;
        send(1, 16'h3C01, 16'h4400);
        seen = 0;
        do begin @(negedge clk); seen++; end while (!rsp_valid && seen < 20);
        r = {rsp_id, rsp_sign_a, rsp_sign_b, rsp_exc, rsp_sticky, rsp_exp, rsp_mant_a, rsp_mant_b};
        chk("lit_bp_sticky", r.st, 1);
        req0_opa = 16'h3800; req0_opb = 16'h3400; req0_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", {rsp_id, rsp_sign_a, rsp_sign_b, rsp_exc, rsp_sticky,
                              rsp_exp, rsp_mant_a, rsp_mant_b}, r);
            chk("bp_ready0", req0_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;

        // Requester 1 withdraws while the block is busy: never issued.
        req1_opa = 16'h1234; req1_opb = 16'h4321; req1_valid = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        get_rsp(r);
        chk("withdraw_prev_id", r.id, 0);
        seen = 0;
        repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
        chk("withdraw_no_rsp", seen, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].r, vecs[i].a, vecs[i].b);
            get_rsp(r);
        end

`ifdef FP16_ALIGN_SCHED_EXC_CNT_EN
        for (int i = 0; i < 300; i++) begin
            send(i % 2, 16'h7C00, 16'h3C00);
            get_rsp(r);
        end
        chk("exc_count_sat", exc_count, 255);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
